rv32i_fetch_unit: RTL and testbench
===================================

Name: rv32i_fetch_unit

Overview:
Instruction fetch stage of the RV32I core. It sits directly upstream of the combinational control/decode block. It owns the architectural PC register and issues word fetches to instruction memory over a valid/ready request and valid response interface. It holds the fetched instruction stable for the control block, then loads the PC the control block computes when the core acknowledges the instruction.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address; bits [1:0] must be 0.
TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before a bus-timeout fault; range 1..65535.

Ports:
clk  in  1  core clock, rising edge.
nrst  in  1  asynchronous active-low reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request.
imem_req_addr  out  32  word-aligned fetch address (= pc_out).
imem_rsp_valid  in  1  response data valid (single-cycle pulse).
imem_rsp_data  in  32  fetched instruction word.
pc_out  out  32  PC of the held instruction; drives the control block's pc.
instr_out  out  32  held instruction; drives the control block's imem_in.
instr_valid  out  1  instr_out/pc_out are valid and stable.
instr_ack  in  1  core retires the held instruction this cycle.
pc_next_in  in  32  next PC from the control block; sampled only on accepted ack.
fetch_fault  out  1  sticky fault flag.
fault_cause  out  2  00 none, 01 misaligned pc_next, 10 bus timeout.
fault_pc  out  32  offending address.
fetch_count  out  32  number of retired (acknowledged) instructions; wraps 0xFFFF_FFFF -> 0.

Behaviour:
- Reset (nrst=0, asynchronous) sets: state IDLE, pc_q=RESET_VECTOR, instr_q=0, timeout counter=0, fetch_count=0, fault_cause=00, fault_pc=0. All outputs are derived from these registers, so imem_req_valid=0, instr_valid=0 and fetch_fault=0.
- Reset release is synchronous in effect: the first rising edge with nrst=1 moves IDLE -> REQ.
- State machine states: IDLE, REQ, WAIT, HOLD, FAULT.
  - REQ: imem_req_valid=1, imem_req_addr=pc_q. Address and valid stay stable until the request is accepted. On imem_req_ready=1, go to WAIT and clear the timeout counter.
  - WAIT: imem_req_valid=0. On imem_rsp_valid=1, instr_q<=imem_rsp_data and go to HOLD. Otherwise increment the counter. If the counter reaches TIMEOUT_CYCLES without a response, go to FAULT with cause 10 and fault_pc=pc_q.
  - HOLD: instr_valid=1. instr_out=instr_q and pc_out=pc_q are held stable. On instr_ack=1:
    - fetch_count increments.
    - pc_q<=pc_next_in.
    - If pc_next_in[1:0]!=0, go to FAULT with cause 01 and fault_pc=pc_next_in.
    - Otherwise go to REQ.
  - FAULT: fetch_fault=1, instr_valid=0, imem_req_valid=0. This state is terminal until reset.
- Minimum latency: a fetch takes at least 3 cycles from REQ entry to instr_valid.
  - Edge 1: request accepted.
  - Edge 2: response captured (earliest response is the cycle after acceptance).
  - instr_valid is high in the following cycle.
- After instr_ack at edge N, imem_req_valid is high in cycle N+1 with the new address.
- Ignored events:
  - imem_rsp_valid outside WAIT, including in the same cycle as acceptance in REQ.
  - instr_ack outside HOLD; it has no effect and does not increment fetch_count.
  - pc_next_in except on an ack in HOLD.
- pc_out/imem_req_addr always equal pc_q. In WAIT and REQ, pc_out is valid but instr_valid=0.
- A response and a timeout in the same cycle resolve in favour of the response.
- fault_cause/fault_pc are written once on FAULT entry and are never overwritten.
- Reset asserted in any state, mid-handshake included, aborts immediately. Any late response after reset is dropped because the state is no longer WAIT.

Test Plan:
1. Reset release with ready=1 and response 1 cycle later (0x00500093): req_addr=0x0, instr_valid rises on the 3rd edge, instr_out=0x00500093, pc_out=0.
2. Hold imem_req_ready=0 for 4 cycles in REQ: req_valid and req_addr stay constant; no response is accepted during that time.
3. Ack with pc_next_in=0x0000_0104: next cycle req_addr=0x104, fetch_count=1; a second ack while instr_valid=0 leaves fetch_count=1.
4. Ack with pc_next_in=0x0000_0102: FAULT, fetch_fault=1, cause=01, fault_pc=0x102, req_valid stays 0 until reset.
5. TIMEOUT_CYCLES=8 with no response: fault with cause=10 after 8 WAIT cycles, fault_pc equals the request address.
6. Assert nrst mid-WAIT, then inject rsp_valid right after release: all outputs return to reset values and the stale response is not captured (instr_valid=0).

Source files
------------

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch stage.
// Owns the architectural PC, issues word fetches over a valid/ready request
// channel, captures the single-cycle response and holds the instruction for
// the decode/control block until the core acknowledges it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | just out of reset, no request yet
// REQ   | request valid at r_pc, waiting for imem_req_ready
// WAIT  | request accepted, waiting for imem_rsp_valid (timeout armed)
// HOLD  | instruction valid and stable, waiting for instr_ack
// FAULT | misaligned next PC or bus timeout; terminal until reset
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nrst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic [31:0] pc_next_in,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b10;

    // Counter value on the last WAIT cycle allowed before the timeout fault.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [15:0] r_cnt;
    logic [31:0] r_fetch_count;
    logic [1:0]  r_fault_cause;
    logic [31:0] r_fault_pc;

    logic        w_ack_taken;
    logic        w_next_misaligned;
    logic        w_timeout;

    assign w_ack_taken       = (r_state == S_HOLD) && instr_ack;
    assign w_next_misaligned = (pc_next_in[1:0] != 2'b00);
    assign w_timeout         = (r_state == S_WAIT) && !imem_rsp_valid && (r_cnt == TO_LAST);

    // State sequencing, PC/instruction capture and timeout counting.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_VECTOR;
            r_instr <= 32'h0;
            r_cnt   <= 16'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (imem_req_ready) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 16'h0;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_instr <= imem_rsp_data;
                        r_state <= S_HOLD;
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_cnt <= r_cnt + 16'h1;
                    end
                end
                S_HOLD: begin
                    if (instr_ack) begin
                        r_pc    <= pc_next_in;
                        r_state <= w_next_misaligned ? S_FAULT : S_REQ;
                    end
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_FAULT;
                end
            endcase
        end
    end

    // Retired-instruction counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_fetch_count <= 32'h0;
        end else if (w_ack_taken) begin
            r_fetch_count <= r_fetch_count + 32'h1;
        end
    end

    // Fault record, written only on the transition into FAULT.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_fault_cause <= CAUSE_NONE;
            r_fault_pc    <= 32'h0;
        end else if (w_timeout) begin
            r_fault_cause <= CAUSE_TIMEOUT;
            r_fault_pc    <= r_pc;
        end else if (w_ack_taken && w_next_misaligned) begin
            r_fault_cause <= CAUSE_MISALIGN;
            r_fault_pc    <= pc_next_in;
        end
    end

    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc;
    assign pc_out         = r_pc;
    assign instr_out      = r_instr;
    assign instr_valid    = (r_state == S_HOLD);
    assign fetch_fault    = (r_state == S_FAULT);
    assign fault_cause    = r_fault_cause;
    assign fault_pc       = r_fault_pc;
    assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Testbench for rv32i_fetch_unit: directed scenarios followed by randomized
// traffic, all compared against a transaction-level reference model.
module tb_rv32i_fetch_unit;

    localparam int TO = 8;

    logic        clk;
    logic        nrst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ack;
    logic [31:0] pc_next_in;
    logic        fetch_fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    rv32i_fetch_unit #(
        .RESET_VECTOR  (32'h0000_0000),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .pc_out        (pc_out),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .instr_ack     (instr_ack),
        .pc_next_in    (pc_next_in),
        .fetch_fault   (fetch_fault),
        .fault_cause   (fault_cause),
        .fault_pc      (fault_pc),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: what the fetch stage is doing, as a transaction phase.
    localparam int P_BOOT    = 0;  // out of reset, request not yet issued
    localparam int P_ASK     = 1;  // asking memory for the word at m_pc
    localparam int P_PENDING = 2;  // asked, answer not yet back
    localparam int P_HAVE    = 3;  // instruction in hand for the core
    localparam int P_DEAD    = 4;  // faulted

    int          m_phase;
    int          m_waited;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_retired;
    logic [1:0]  m_cause;
    logic [31:0] m_fpc;

    task automatic model_reset();
        m_phase   = P_BOOT;
        m_waited  = 0;
        m_pc      = 32'h0;
        m_instr   = 32'h0;
        m_retired = 32'h0;
        m_cause   = 2'b00;
        m_fpc     = 32'h0;
    endtask

    task automatic model_clock(input logic rdy, input logic rv, input logic [31:0] rd,
                               input logic ack, input logic [31:0] pn);
        if (m_phase == P_BOOT) begin
            m_phase = P_ASK;
        end else if (m_phase == P_ASK) begin
            if (rdy) begin
                m_phase  = P_PENDING;
                m_waited = 0;
            end
        end else if (m_phase == P_PENDING) begin
            m_waited = m_waited + 1;
            if (rv) begin
                m_instr = rd;
                m_phase = P_HAVE;
            end else if (m_waited >= TO) begin
                m_phase = P_DEAD;
                m_cause = 2'b10;
                m_fpc   = m_pc;
            end
        end else if (m_phase == P_HAVE) begin
            if (ack) begin
                m_retired = m_retired + 1;
                m_pc      = pn;
                if (pn % 4 != 0) begin
                    m_phase = P_DEAD;
                    m_cause = 2'b01;
                    m_fpc   = pn;
                end else begin
                    m_phase = P_ASK;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".req_valid"},   32'(imem_req_valid), 32'(m_phase == P_ASK));
        check({tag, ".req_addr"},    imem_req_addr,       m_pc);
        check({tag, ".pc_out"},      pc_out,              m_pc);
        check({tag, ".instr_valid"}, 32'(instr_valid),    32'(m_phase == P_HAVE));
        check({tag, ".instr_out"},   instr_out,           m_instr);
        check({tag, ".fetch_fault"}, 32'(fetch_fault),    32'(m_phase == P_DEAD));
        check({tag, ".fault_cause"}, 32'(fault_cause),    32'(m_cause));
        check({tag, ".fault_pc"},    fault_pc,            m_fpc);
        check({tag, ".fetch_count"}, fetch_count,         m_retired);
    endtask

    // Called at a falling edge: drive inputs, clock once, check at next falling edge.
    task automatic step(input string tag, input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic ack, input logic [31:0] pn);
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        instr_ack      = ack;
        pc_next_in     = pn;
        @(posedge clk);
        model_clock(rdy, rv, rd, ack, pn);
        @(negedge clk);
        check_all(tag);
    endtask

    // Called at a falling edge: asynchronous reset assertion, release at next falling edge.
    task automatic do_reset(input string tag);
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        check_all({tag, ".async"});
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        nrst           = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ack      = 1'b0;
        pc_next_in     = 32'h0;
        model_reset();
        @(negedge clk);
        check_all("reset");
        nrst = 1'b1;

        // Reset release, ready high, response one cycle after acceptance.
        step("t1.e0", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t1.req_valid", 32'(imem_req_valid), 32'd1);
        check("t1.req_addr", imem_req_addr, 32'h0);
        step("t1.e1", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        check("t1.not_valid_yet", 32'(instr_valid), 32'd0);
        step("t1.e2", 1'b0, 1'b1, 32'h0050_0093, 1'b0, 32'h0);
        check("t1.instr_valid", 32'(instr_valid), 32'd1);
        check("t1.instr_out", instr_out, 32'h0050_0093);
        check("t1.pc_out", pc_out, 32'h0);

        // Ack to 0x104, then stall the request for 4 cycles with stray responses.
        step("t3.ack", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0104);
        check("t3.req_addr", imem_req_addr, 32'h0000_0104);
        check("t3.count", fetch_count, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step("t2.stall", 1'b0, 1'b1, 32'h1234_5678 + 32'(i), 1'b0, 32'h0);
            check("t2.req_valid", 32'(imem_req_valid), 32'd1);
            check("t2.req_addr", imem_req_addr, 32'h0000_0104);
            check("t2.instr_out", instr_out, 32'h0050_0093);
        end
        step("t3.stray_ack", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0200);
        check("t3.count_hold", fetch_count, 32'd1);
        check("t3.addr_hold", imem_req_addr, 32'h0000_0104);

        // Misaligned next PC.
        step("t4.acc", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step("t4.rsp", 1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0);
        step("t4.ack", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0102);
        check("t4.fault", 32'(fetch_fault), 32'd1);
        check("t4.cause", 32'(fault_cause), 32'd1);
        check("t4.fault_pc", fault_pc, 32'h0000_0102);
        check("t4.count", fetch_count, 32'd2);
        for (int i = 0; i < 3; i++) begin
            step("t4.stuck", 1'b1, 1'b1, 32'h0, 1'b1, 32'h0000_0300);
            check("t4.req_valid", 32'(imem_req_valid), 32'd0);
            check("t4.cause_kept", 32'(fault_cause), 32'd1);
        end

        // Timeout after TO wait cycles.
        do_reset("t5");
        step("t5.boot", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("t5.acc", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < TO - 1; i++) begin
            step("t5.wait", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            check("t5.no_fault", 32'(fetch_fault), 32'd0);
        end
        step("t5.expire", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t5.fault", 32'(fetch_fault), 32'd1);
        check("t5.cause", 32'(fault_cause), 32'd2);
        check("t5.fault_pc", fault_pc, 32'h0);

        // Response on the last allowed wait cycle wins over the timeout.
        do_reset("tr");
        step("tr.boot", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("tr.acc", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < TO - 1; i++) step("tr.wait", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("tr.rsp", 1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 32'h0);
        check("tr.instr_valid", 32'(instr_valid), 32'd1);
        check("tr.no_fault", 32'(fetch_fault), 32'd0);

        // Reset mid-WAIT, stale response right after release.
        do_reset("t6a");
        step("t6.boot", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("t6.acc", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step("t6.wait", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        do_reset("t6");
        step("t6.stale", 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 32'h0);
        check("t6.instr_valid", 32'(instr_valid), 32'd0);
        check("t6.instr_out", instr_out, 32'h0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] pn;
            if ((m_phase == P_DEAD && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset("rnd");
            end
            pn = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) pn[1:0] = 2'($urandom_range(1, 3));
            step("rnd", 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4), $urandom,
                 ($urandom_range(0, 2) == 0), pn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
